// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with shadow/display double buffering, blink and blanking.
// Latency: AN/SEGMENT registered, one cycle behind the digit index; loads reach the display on the next frame wrap.
// Backpressure: none; load is always accepted, a newer load overwrites an untransferred shadow (pending flags it).
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  point,
    input  logic [7:0]  blank,
    input  logic [7:0]  blink,
    input  logic        load,
    output logic        pending,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [15:0] scan_cnt;
    logic [2:0]  idx;
    logic [7:0]  frame_cnt;
    logic        blink_phase;

    logic [31:0] shadow_data;
    logic [7:0]  shadow_point;
    logic [7:0]  shadow_blank;
    logic [7:0]  shadow_blink;

    logic [31:0] disp_data;
    logic [7:0]  disp_point;
    logic [7:0]  disp_blank;
    logic [7:0]  disp_blink;

    logic        scan_tc;
    logic        wrap;
    logic [3:0]  cur_nib;
    logic        cur_dark;
    logic [7:0]  seg_next;

    // Active-low {a..g} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Terminal count of the per-digit dwell, and the frame wrap (last digit finishing).
    always_comb begin
        scan_tc = (scan_cnt == SCAN_LAST);
        wrap    = scan_tc && (idx == 3'd7);
    end

    // Dwell counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Frame counter; toggles the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Shadow capture and frame-aligned transfer; the display only changes at the wrap,
    // and a load on the wrap cycle still transfers the older shadow while capturing the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_point <= '0;
            shadow_blank <= '0;
            shadow_blink <= '0;
            disp_data    <= '0;
            disp_point   <= '0;
            disp_blank   <= '0;
            disp_blink   <= '0;
            pending      <= 1'b0;
        end else begin
            if (wrap && pending) begin
                disp_data  <= shadow_data;
                disp_point <= shadow_point;
                disp_blank <= shadow_blank;
                disp_blink <= shadow_blink;
            end
            if (load) begin
                shadow_data  <= data;
                shadow_point <= point;
                shadow_blank <= blank;
                shadow_blink <= blink;
                pending      <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
    logic [7:0] lz;
    assign lz[0] = 1'b0;
    for (genvar k = 1; k < 8; k++) begin : g_lz
        assign lz[k] = (disp_data[31:4*k] == '0);
    end
`endif

    // Segment pattern for the digit currently selected by idx.
    always_comb begin
        cur_nib  = disp_data[{idx, 2'b00} +: 4];
        cur_dark = disp_blank[idx] | (disp_blink[idx] & blink_phase);
        if (cur_dark) begin
            seg_next = 8'hFF;
`ifdef SEG7_LZB_EN
        end else if (lz[idx]) begin
            seg_next = {7'h7F, ~disp_point[idx]};
`endif
        end else begin
            seg_next = {hex_decode(cur_nib), ~disp_point[idx]};
        end
    end

    // Registered display drive and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            AN      <= 8'hFF;
            SEGMENT <= 8'hFF;
            frame   <= 1'b0;
        end else begin
            AN      <= ~(8'h01 << idx);
            SEGMENT <= seg_next;
            frame   <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
// Checks reset, scan timing, shadow/display transfer, blink, blank and leading-zero behaviour.
// All expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic        load;
    logic        pending;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .point   (point),
        .blank   (blank),
        .blink   (blink),
        .load    (load),
        .pending (pending),
        .AN      (AN),
        .SEGMENT (SEGMENT),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the frame pulse is seen, bounded.
    task automatic wait_frame();
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (frame !== 1'b1 && i < 100);
        check("frame_seen", {31'd0, frame}, 32'd1);
    endtask

    // From a frame point, walk one full frame: each digit lit 4 cycles with its expected
    // pattern; frame must be low until the final cycle, where the next pulse lands.
    // e packs {d7,...,d0}.
    task automatic scan_frame(input string name, input logic [63:0] e);
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        for (int d = 0; d < 8; d++) begin
            exp_an  = ~(8'h01 << d);
            exp_seg = e[8*d +: 8];
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("%s_an_d%0d_c%0d", name, d, c), {24'd0, AN}, {24'd0, exp_an});
                check($sformatf("%s_seg_d%0d_c%0d", name, d, c), {24'd0, SEGMENT}, {24'd0, exp_seg});
                if (c == 3)
                    check($sformatf("%s_frame_d%0d", name, d), {31'd0, frame}, {31'd0, (d == 7)});
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        data  = '0;
        point = '0;
        blank = '0;
        blink = '0;
        load  = 1'b0;

        // Reset state
        ticks(3);
        check("rst_an", {24'd0, AN}, 32'h0000_00FF);
        check("rst_seg", {24'd0, SEGMENT}, 32'h0000_00FF);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_frame", {31'd0, frame}, 32'd0);

        // First edge after release drives digit 0 of the all-zero display
        rst = 1'b0;
        tick();
        check("rel_an", {24'd0, AN}, 32'h0000_00FE);
        check("rel_seg", {24'd0, SEGMENT}, 32'h0000_0003);

        // Load 0000_0001, appears after the first frame wrap
        data = 32'h0000_0001;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("ld1_pending", {31'd0, pending}, 32'd1);
        wait_frame();
        check("ld1_pending_clr", {31'd0, pending}, 32'd0);
        scan_frame("one", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h9F});

        // Mid-frame load: display unchanged until the wrap
        ticks(10);
        data  = 32'h8888_8888;
        point = 8'hFF;
        load  = 1'b1;
        tick();
        load = 1'b0;
        check("mid_pending", {31'd0, pending}, 32'd1);
        check("mid_an", {24'd0, AN}, 32'h0000_00FB);
        check("mid_seg_old", {24'd0, SEGMENT}, 32'h0000_0003);
        wait_frame();
        check("mid_pending_clr", {31'd0, pending}, 32'd0);
        scan_frame("eights", {8{8'h00}});

        // Two loads before a wrap: last one wins
        ticks(5);
        data  = 32'h1111_1111;
        point = 8'h00;
        load  = 1'b1;
        tick();
        data = 32'h2222_2222;
        tick();
        load = 1'b0;
        wait_frame();
        check("two_pending_clr", {31'd0, pending}, 32'd0);
        scan_frame("twos", {8{8'h25}});

        // Load on the wrap cycle with a pending shadow: old transfers, new stays pending
        ticks(5);
        data = 32'h4444_4444;
        load = 1'b1;
        tick();
        load = 1'b0;
        ticks(25);
        data = 32'h3333_3333;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("coin_frame", {31'd0, frame}, 32'd1);
        check("coin_pending", {31'd0, pending}, 32'd1);
        scan_frame("fours", {8{8'h99}});
        check("coin_pending_clr", {31'd0, pending}, 32'd0);
        scan_frame("threes", {8{8'h0D}});

        // Reset at digit 5 with a pending shadow discards it
        data = 32'h5555_5555;
        load = 1'b1;
        tick();
        load = 1'b0;
        ticks(21);
        check("pre_rst_an", {24'd0, AN}, 32'h0000_00DF);
        check("pre_rst_pending", {31'd0, pending}, 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_an", {24'd0, AN}, 32'h0000_00FF);
        check("mrst_seg", {24'd0, SEGMENT}, 32'h0000_00FF);
        check("mrst_pending", {31'd0, pending}, 32'd0);
        check("mrst_frame", {31'd0, frame}, 32'd0);
        rst = 1'b0;
        tick();
        check("mrel_an", {24'd0, AN}, 32'h0000_00FE);
        check("mrel_seg", {24'd0, SEGMENT}, 32'h0000_0003);
        check("mrel_pending", {31'd0, pending}, 32'd0);

        // Blink on digit 0, blank on digit 1 (its point suppressed), point on digit 2
        data  = 32'h0000_0000;
        point = 8'h06;
        blank = 8'h02;
        blink = 8'h01;
        load  = 1'b1;
        tick();
        load = 1'b0;
        wait_frame();
        scan_frame("blk1", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'hFF, 8'h03});
        scan_frame("blk2", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'hFF, 8'hFF});
        scan_frame("blk3", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'hFF, 8'hFF});
        scan_frame("blk4", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'hFF, 8'h03});
        scan_frame("blk5", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'hFF, 8'h03});

        // Leading zeros: suppressed only when the blanking option is built in
        data  = 32'h0000_0100;
        point = 8'h10;
        blank = 8'h00;
        blink = 8'h00;
        load  = 1'b1;
        tick();
        load = 1'b0;
        wait_frame();
`ifdef SEG7_LZB_EN
        scan_frame("lzb", {8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'h9F, 8'h03, 8'h03});
`else
        scan_frame("nolzb", {8'h03, 8'h03, 8'h03, 8'h02, 8'h03, 8'h9F, 8'h03, 8'h03});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit stays lit; legal range 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 64: full 8-digit frames per blink half-period; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 data  in  32  eight hex digits; digit k is data[4k+3:4k], digit 7 leftmost.
REQ-006 point  in  8  per-digit decimal point request; bit k lights the point of digit k.
REQ-007 blank  in  8  per-digit force-off; bit k dark turns digit k fully off.
REQ-008 blink  in  8  per-digit blink enable; bit k set blinks digit k.
REQ-009 load  in  1  one-cycle strobe capturing data/point/blank/blink into the shadow register.
REQ-010 pending  out  1  high while a shadow value awaits transfer to the display register.
REQ-011 AN  out  8  active-low digit enables; exactly one bit low outside reset.
REQ-012 SEGMENT  out  8  active-low segments ordered {a,b,c,d,e,f,g,p}.
REQ-013 frame  out  1  one-cycle pulse on each digit-7-to-digit-0 wrap.

Function
REQ-014 A 16-bit scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index (3 bits) SHALL advance, 7 wrapping to 0.
REQ-015 AN and SEGMENT SHALL be registered and reflect the current digit index one cycle after it changes; AN = ~(8'h01 << idx).
REQ-016 Hex decode, active-low {a..g}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-017 Bit p SHALL be 0 when the digit's point bit is set and the digit is not dark, otherwise 1.
REQ-018 A digit is dark, with SEGMENT = 8'hFF, when its blank bit is set, or when its blink bit is set and blink phase = 1.
REQ-019 load SHALL copy all four inputs into the shadow register and set pending; a load while pending already set SHALL overwrite the shadow (last wins).
REQ-020 On the cycle frame pulses, a pending shadow SHALL move to the display register and pending SHALL clear; the display never changes mid-frame.
REQ-021 If load and the frame pulse coincide, the old shadow SHALL transfer, the new value SHALL be captured, and pending SHALL remain 1.
REQ-022 An 8-bit frame counter SHALL count frames; on reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle the blink phase.
REQ-023 frame SHALL assert exactly one cycle per 8*SCAN_DIV cycles, coincident with idx changing 7->0.

Reset
REQ-024 On rst: scan counter, idx, frame counter, blink phase = 0; pending = 0; frame = 0; shadow and display registers all zero; AN = 8'hFF; SEGMENT = 8'hFF.
REQ-025 rst mid-frame SHALL discard any pending shadow; after rst release, AN = 8'hFE on the first clock edge.

Configuration
REQ-026 Macro SEG7_LZB_EN defined: leading-zero blanking SHALL be compiled in, darkening digit k (k=7..1) when its nibble and all higher nibbles are zero; the point still shows per REQ-017 (8'hFE when set); digit 0 is never blanked.
REQ-027 Macro SEG7_LZB_EN undefined: all digits SHALL display their nibble, with no zero-suppression logic present.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 rst, then load data=32'h0000_0001, wait for frame -> at idx 0, AN=8'hFE and SEGMENT=8'h9F; each digit lit 4 cycles; frame period 32 cycles.
REQ-029 load data=32'h8888_8888 point=8'hFF mid-frame -> pending=1, display unchanged until frame; next frame shows SEGMENT=8'h00 on every digit; pending=0.
REQ-030 blink=8'h01, data=0 -> digit 0 shows 8'h03 for 2 frames, then 8'hFF for 2 frames, repeating.
REQ-031 Two loads (values A, then B) before a frame -> display shows B only; load coincident with frame -> old shadow shown and pending stays 1.
REQ-032 With SEG7_LZB_EN, data=32'h0000_0100, point=8'h10 -> digits 7,6,5,3 = 8'hFF; digit 4 = 8'hFE; digit 2 = 8'h9F; digits 1,0 = 8'h03.
REQ-033 Assert rst at idx 5 with pending=1 -> next cycle AN=8'hFF, SEGMENT=8'hFF, pending=0; after release, scanning restarts at digit 0 showing 8'h03.
